// File: rtl/trdb_pkg.sv
// Shared trace-debug constants. The branch map, priority stage and packet
// assembler all size their branch-map fields from these.
package trdb_pkg;

  localparam int unsigned BRANCH_MAP_LEN = 31;
  localparam int unsigned BRANCH_CNT_W   = 5;

endpackage

// File: rtl/trdb_branch_map.sv
// Branch map collector: records retired conditional-branch outcomes and hands
// a snapshot to the packet assembler on flush. Optional sticky overflow flag
// is enabled by defining TRDB_BRANCH_MAP_OVERFLOW_EN.
module trdb_branch_map
  import trdb_pkg::*;
#(
  parameter int unsigned MAP_LEN = BRANCH_MAP_LEN,
  parameter int unsigned CNT_W   = $clog2(MAP_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic               is_branch_i,
  input  logic               branch_taken_i,
  input  logic               flush_i,
  output logic [MAP_LEN-1:0] map_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               is_full_o,
  output logic               is_empty_o,
  output logic               snap_valid_o,
  output logic [MAP_LEN-1:0] snap_map_o,
  output logic [CNT_W-1:0]   snap_cnt_o,
  output logic               overflow_o
);

  logic [MAP_LEN-1:0] map_q, map_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAP_LEN-1:0] snap_map_q, snap_map_d;
  logic [CNT_W-1:0]   snap_cnt_q, snap_cnt_d;
  logic               snap_valid_q, snap_valid_d;
  logic               br;
  logic               is_full;
  logic               drop;
  logic [MAP_LEN-1:0] new_bit;

  assign br      = valid_i & is_branch_i;
  assign is_full = (cnt_q == CNT_W'(MAP_LEN));
  // Encoding is inverted: a set bit means not taken.
  assign new_bit = {{(MAP_LEN-1){1'b0}}, ~branch_taken_i};

  always_comb begin
    map_d        = map_q;
    cnt_d        = cnt_q;
    snap_map_d   = snap_map_q;
    snap_cnt_d   = snap_cnt_q;
    snap_valid_d = 1'b0;
    drop         = 1'b0;
    if (clear_i) begin
      map_d      = '0;
      cnt_d      = '0;
      snap_map_d = '0;
      snap_cnt_d = '0;
    end else if (flush_i) begin
      snap_map_d   = map_q;
      snap_cnt_d   = cnt_q;
      snap_valid_d = 1'b1;
      // A branch retiring alongside the flush opens the next map.
      map_d        = br ? new_bit : '0;
      cnt_d        = br ? CNT_W'(1) : '0;
    end else if (br) begin
      if (!is_full) begin
        map_d = map_q | (new_bit << cnt_q);
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_q        <= '0;
      cnt_q        <= '0;
      snap_map_q   <= '0;
      snap_cnt_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      map_q        <= map_d;
      cnt_q        <= cnt_d;
      snap_map_q   <= snap_map_d;
      snap_cnt_q   <= snap_cnt_d;
      snap_valid_q <= snap_valid_d;
    end
  end

`ifdef TRDB_BRANCH_MAP_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;

  // The priority stage is expected to flush before a full map sees another branch.
  a_no_drop : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(br && is_full && !flush_i && !clear_i))
    else $error("branch dropped on full map");
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign overflow_o  = 1'b0;
`endif

  assign map_o        = map_q;
  assign cnt_o        = cnt_q;
  assign is_full_o    = is_full;
  assign is_empty_o   = (cnt_q == '0);
  assign snap_valid_o = snap_valid_q;
  assign snap_map_o   = snap_map_q;
  assign snap_cnt_o   = snap_cnt_q;

endmodule

// File: tb/tb_trdb_branch_map.sv
// Scoreboard bench for trdb_branch_map: a branch-history queue model predicts
// live and snapshot state; a monitor compares after every clock edge.
module tb_trdb_branch_map;
  import trdb_pkg::*;

  localparam int ML = BRANCH_MAP_LEN;
  localparam int CW = BRANCH_CNT_W;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0, valid_i = 1'b0, is_branch_i = 1'b0;
  logic          branch_taken_i = 1'b0, flush_i = 1'b0;
  logic [ML-1:0] map_o, snap_map_o;
  logic [CW-1:0] cnt_o, snap_cnt_o;
  logic          is_full_o, is_empty_o, snap_valid_o, overflow_o;

  trdb_branch_map dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
    .is_branch_i(is_branch_i), .branch_taken_i(branch_taken_i), .flush_i(flush_i),
    .map_o(map_o), .cnt_o(cnt_o), .is_full_o(is_full_o), .is_empty_o(is_empty_o),
    .snap_valid_o(snap_valid_o), .snap_map_o(snap_map_o), .snap_cnt_o(snap_cnt_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [ML-1:0] map; int cnt; bit ovf; bit sv;} live_t;
  typedef struct {logic [ML-1:0] map; int cnt;} snap_t;

  live_t live_q[$];
  snap_t snap_q[$];
  live_t me;
  snap_t ms;
  bit    hist[$];   // oldest first, 1 = not taken
  bit    m_ovf = 1'b0;
  int    errors = 0;
  int    checks = 0;

`ifdef TRDB_BRANCH_MAP_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  function automatic logic [ML-1:0] model_map();
    logic [ML-1:0] m = '0;
    foreach (hist[i]) if (hist[i]) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what the next edge must produce.
  task automatic cycle(bit clr, bit fl, bit v, bit isb, bit tk);
    bit    br;
    live_t e;
    snap_t s;
    @(negedge clk_i);
    clear_i = clr; flush_i = fl; valid_i = v; is_branch_i = isb; branch_taken_i = tk;
    br = v & isb;
    e.sv = 1'b0;
    if (clr) begin
      hist.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      s.map = model_map();
      s.cnt = hist.size();
      snap_q.push_back(s);
      e.sv = 1'b1;
      hist.delete();
      if (br) hist.push_back(!tk);
    end else if (br) begin
      if (hist.size() < ML) hist.push_back(!tk);
      else if (OVF_EN) m_ovf = 1'b1;
    end
    e.map = model_map();
    e.cnt = hist.size();
    e.ovf = m_ovf;
    live_q.push_back(e);
  endtask

  task automatic branches(int n, bit rand_tk);
    for (int i = 0; i < n; i++) cycle(0, 0, 1, 1, rand_tk ? 1'($urandom_range(1)) : 1'b1);
  endtask

  always @(posedge clk_i) begin
    #1;
    if (rst_ni && live_q.size() > 0) begin
      me = live_q.pop_front();
      chk("map", 64'(map_o), 64'(me.map));
      chk("cnt", 64'(cnt_o), 64'(me.cnt));
      chk("full", 64'(is_full_o), 64'(me.cnt == ML));
      chk("empty", 64'(is_empty_o), 64'(me.cnt == 0));
      chk("overflow", 64'(overflow_o), 64'(me.ovf));
      chk("snap_valid", 64'(snap_valid_o), 64'(me.sv));
      if (me.sv) begin
        if (snap_q.size() == 0) begin
          chk("snap_queue_underrun", 64'(1), 64'(0));
        end else begin
          ms = snap_q.pop_front();
          chk("snap_map", 64'(snap_map_o), 64'(ms.map));
          chk("snap_cnt", 64'(snap_cnt_o), 64'(ms.cnt));
        end
      end
    end
  end

  task automatic check_reset_vals(string tag);
    chk({tag, "_map"}, 64'(map_o), 64'(0));
    chk({tag, "_cnt"}, 64'(cnt_o), 64'(0));
    chk({tag, "_full"}, 64'(is_full_o), 64'(0));
    chk({tag, "_empty"}, 64'(is_empty_o), 64'(1));
    chk({tag, "_snap_valid"}, 64'(snap_valid_o), 64'(0));
    chk({tag, "_snap_map"}, 64'(snap_map_o), 64'(0));
    chk({tag, "_snap_cnt"}, 64'(snap_cnt_o), 64'(0));
    chk({tag, "_overflow"}, 64'(overflow_o), 64'(0));
  endtask

  task automatic after_edge();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    #12;
    check_reset_vals("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // taken, not-taken, taken
    cycle(0, 0, 1, 1, 1);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 1);
    after_edge();
    chk("three_map", 64'(map_o), 64'(3'b010));
    chk("three_cnt", 64'(cnt_o), 64'(3));
    cycle(0, 1, 0, 0, 0);

    // fill to full with taken branches, then flush
    branches(31, 1'b0);
    for (int i = 0; i < 31; i++) hist[i] = hist[i];
    cycle(0, 0, 0, 0, 0);
    after_edge();
    chk("full_flag", 64'(is_full_o), 64'(1));
    chk("full_map", 64'(map_o), 64'(0));
    cycle(0, 1, 0, 0, 0);
    after_edge();
    chk("full_snap_cnt", 64'(snap_cnt_o), 64'(31));
    chk("full_after_empty", 64'(is_empty_o), 64'(1));
    cycle(0, 0, 0, 0, 0);
    after_edge();
    chk("snap_pulse_drop", 64'(snap_valid_o), 64'(0));

    // flush with simultaneous not-taken branch at cnt 5
    branches(5, 1'b1);
    cycle(0, 1, 1, 1, 0);
    after_edge();
    chk("flushbr_snap_cnt", 64'(snap_cnt_o), 64'(5));
    chk("flushbr_cnt", 64'(cnt_o), 64'(1));
    chk("flushbr_map", 64'(map_o), 64'(1));

    // overflow on full map without flush
    branches(30, 1'b1);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0);
    after_edge();
    chk("ovf_cnt_held", 64'(cnt_o), 64'(31));
    chk("ovf_flag", 64'(overflow_o), 64'(OVF_EN));
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    after_edge();
    chk("ovf_cleared", 64'(overflow_o), 64'(0));

    // clear beats simultaneous flush and branch at cnt 7
    branches(7, 1'b1);
    cycle(1, 1, 1, 1, 0);
    after_edge();
    chk("clear_cnt", 64'(cnt_o), 64'(0));
    chk("clear_snap_valid", 64'(snap_valid_o), 64'(0));

    // asynchronous reset mid-collection at cnt 12
    branches(12, 1'b1);
    cycle(0, 0, 0, 0, 0);
    after_edge();
    chk("pre_reset_cnt", 64'(cnt_o), 64'(12));
    @(negedge clk_i);
    valid_i = 1'b0; is_branch_i = 1'b0; flush_i = 1'b0; clear_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1 check_reset_vals("async_reset");
    hist.delete();
    m_ovf = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // randomized traffic; flush rate varies so maps sometimes fill
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 500; i++) begin
        bit clr, fl, v, isb;
        clr = ($urandom_range(199) == 0);
        fl  = ($urandom_range(ph * 12 + 3) == 0);
        v   = ($urandom_range(3) != 0);
        isb = ($urandom_range(2) != 0);
        // keep the full-and-dropped case rare so the sticky flag is exercised
        if (hist.size() == ML && $urandom_range(3) != 0) fl = 1'b1;
        cycle(clr, fl, v, isb, 1'($urandom_range(1)));
      end
    end

    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    after_edge();
    chk("live_queue_drained", 64'(live_q.size()), 64'(0));
    chk("snap_queue_drained", 64'(snap_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
